// File: rtl/param_instruction_memory.sv
// Clocked instruction memory for the IF stage. It returns whole blocks after a programmable
// latency, keeps a one-block buffer for zero-stall repeat fetches, and has a word-wide load port.
module param_instruction_memory #(
  parameter int    MEM_BYTES    = 1024,
  parameter int    BLOCK_WORDS  = 4,
  parameter int    ADDR_WIDTH   = 28,
  parameter int    READ_LATENCY = 5,
  parameter string INIT_FILE    = "",
  localparam int   LW           = $clog2(MEM_BYTES / 4)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic [ADDR_WIDTH-1:0]    address,
  output logic [32*BLOCK_WORDS-1:0] readinst,
  output logic                     busywait,
  output logic                     addr_error,
  input  logic                     load_en,
  input  logic [LW-1:0]            load_addr,
  input  logic [31:0]              load_data
);

  localparam int NUM_WORDS  = MEM_BYTES / 4;
  localparam int NUM_BLOCKS = NUM_WORDS / BLOCK_WORDS;
  localparam int WOW        = $clog2(BLOCK_WORDS);
  localparam int LCW        = $clog2(READ_LATENCY + 1);
  localparam int CW         = ((ADDR_WIDTH > LW) ? ADDR_WIDTH : LW) + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [31:0]              mem_r [NUM_WORDS];
  logic [0:0]               state_r;
  logic [LCW-1:0]           lat_cnt_r;
  logic [ADDR_WIDTH-1:0]    buf_addr_r;
  logic                     buf_valid_r;
  logic [32*BLOCK_WORDS-1:0] readinst_r;
  logic                     addr_error_r;

  logic                     hit_s;
  logic                     in_range_s;
  logic                     load_hit_s;
  logic [LW-1:0]            blk_base_s;
  logic [32*BLOCK_WORDS-1:0] blk_data_s;

  assign hit_s      = buf_valid_r && (address == buf_addr_r);
  // Widened compares so NUM_BLOCKS is never truncated to the address width.
  assign in_range_s = (CW'(buf_addr_r) < CW'(NUM_BLOCKS));
  assign load_hit_s = (CW'(load_addr >> WOW) == CW'(buf_addr_r));
  assign blk_base_s = LW'(buf_addr_r) << WOW;

  assign busywait   = (state_r == BUSY) || ((state_r == IDLE) && read && !hit_s);
  assign readinst   = readinst_r;
  assign addr_error = addr_error_r;

  // Gather the buffered block's words from the array (pre-write view at the capture edge).
  always_comb begin
    blk_data_s = '0;
    for (int w = 0; w < BLOCK_WORDS; w++) begin
      blk_data_s[32*w +: 32] = mem_r[blk_base_s + LW'(w)];
    end
  end

  // Program-load write port; the array is deliberately not reset.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem_r[load_addr] <= load_data;
    end
  end

  // Fetch FSM, latency counter, block buffer and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      lat_cnt_r    <= '0;
      buf_addr_r   <= '0;
      buf_valid_r  <= 1'b0;
      readinst_r   <= '0;
      addr_error_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (read && !hit_s) begin
            buf_addr_r <= address;
            lat_cnt_r  <= LCW'(READ_LATENCY - 1);
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          if (lat_cnt_r != '0) begin
            lat_cnt_r <= lat_cnt_r - LCW'(1);
          end else begin
            if (in_range_s) begin
              readinst_r   <= blk_data_s;
              addr_error_r <= 1'b0;
            end else begin
              readinst_r   <= '0;
              addr_error_r <= 1'b1;
            end
            buf_valid_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
      // A load into the buffered block overrides any same-edge capture.
      if (load_en && load_hit_s) begin
        buf_valid_r <= 1'b0;
      end
    end
  end

endmodule
